// File: rtl/opcode_fetch.sv
// opcode_fetch: latches the fetched opcode, or injects BRK when a reset, NMI or IRQ sequence must run.
module opcode_fetch #(
   parameter logic [7:0] BRK_OPCODE = 8'h00
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] dataBus,
   input  logic       getInstruction,
   input  logic       nNMI,
   input  logic       nIRQ,
   input  logic       iFlag,
   output logic [7:0] opcodeNext,
   output logic [7:0] opcode,
   output logic [1:0] interruptSource,
   output logic       pcHold
);
   typedef enum logic [1:0] {NONE, RESET, NMI, IRQ} source_t;
   logic nmiSync1, nmiSync2, nmiPrev, irqSync1, irqSync2;
   logic nmiPending, resetPending, nmiEdge, irqActive;
   source_t source;
   assign nmiEdge = nmiPrev & ~nmiSync2;
   assign irqActive = ~irqSync2 & ~iFlag;
   always_comb source = resetPending ? RESET : nmiPending ? NMI : irqActive ? IRQ : NONE;
   assign opcodeNext = (source != NONE) ? BRK_OPCODE : dataBus;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         {nmiSync1, nmiSync2, nmiPrev, irqSync1, irqSync2} <= 5'b11111;
         nmiPending <= 1'b0;
         resetPending <= 1'b1;
         opcode <= 8'h00;
         interruptSource <= NONE;
         pcHold <= 1'b0;
      end else begin
         nmiSync1 <= nNMI;
         nmiSync2 <= nmiSync1;
         nmiPrev <= nmiSync2;
         irqSync1 <= nIRQ;
         irqSync2 <= irqSync1;
         // a new edge wins over the clear from an NMI fetch in the same cycle
         nmiPending <= nmiEdge | (nmiPending & ~(getInstruction & (source == NMI)));
         if (getInstruction) begin
            resetPending <= 1'b0;
            opcode <= opcodeNext;
            interruptSource <= source;
            pcHold <= (source != NONE);
         end
      end
endmodule

// File: doc/opcode_fetch.md
# opcode_fetch

Captures the opcode byte from the data bus on each instruction-fetch cycle and forces a BRK (0x00) in its place when a reset, NMI or IRQ sequence must run. Feeds the instruction decoder, whose decodedInstruction/decodedAddress go to the timing state machine, and tells the datapath which vector to use and whether to suppress the PC increment. Owns NMI edge detection, IRQ/NMI input synchronisation and the post-reset sequence flag.

## Interface
- `BRK_OPCODE`, default 8'h00: opcode injected for any interrupt sequence.
- `clk` in 1: system clock, all flops on posedge.
- `nrst` in 1: asynchronous, active-low reset.
- `dataBus` in 8: external data bus; holds the opcode during a fetch cycle.
- `getInstruction` in 1: high in the cycle whose closing posedge latches the next opcode; same signal the timing state machine uses.
- `nNMI` in 1: non-maskable interrupt pin, active low, asynchronous, falling-edge sensitive.
- `nIRQ` in 1: interrupt request pin, active low, asynchronous, level sensitive.
- `iFlag` in 1: processor status I bit; 1 masks IRQ.
- `opcodeNext` out 8: combinational opcode selected for this fetch; drives the decoder.
- `opcode` out 8: registered opcode of the instruction now executing.
- `interruptSource` out 2: registered; 0 NONE, 1 RESET, 2 NMI, 3 IRQ.
- `pcHold` out 1: registered; 1 when `interruptSource` != NONE, so the datapath does not increment PC past the fetched byte.

## Operation
- Synchronisers: `nNMI` and `nIRQ` each pass through two flops (`nmiSync1`/`nmiSync2`, `irqSync1`/`irqSync2`). A third flop `nmiPrev` holds the previous `nmiSync2`.
- `nmiEdge` = `nmiPrev` & ~`nmiSync2`, combinational.
- `nmiPending`: set on any posedge where `nmiEdge`=1. Cleared on a posedge where `getInstruction`=1 and NMI is the selected source. If `nmiEdge` and the clear coincide, set wins and the flag stays 1.
- `resetPending`: 1 out of reset; cleared on the first posedge with `getInstruction`=1.
- `irqActive` = ~`irqSync2` & ~`iFlag`. No latch: IRQ is taken only if still asserted at fetch.
- Priority at a fetch, evaluated combinationally every cycle:
  - RESET if `resetPending`;
  - else NMI if `nmiPending`;
  - else IRQ if `irqActive`;
  - else NONE.
- `opcodeNext` = `BRK_OPCODE` when the selected source != NONE, else `dataBus`.
- On a posedge with `getInstruction`=1: `opcode` <= `opcodeNext`, `interruptSource` <= selected source, `pcHold` <= (source != NONE).
- With `getInstruction`=0 all three registered outputs hold their values.
- A held NMI (pin stays low) yields exactly one NMI. Another NMI needs `nNMI` to return high and fall again.

## Timing
- Reset values:
  - `opcode`=0x00, `interruptSource`=0, `pcHold`=0;
  - `resetPending`=1, `nmiPending`=0;
  - all sync flops and `nmiPrev`=1 (pins idle high).
- Reset mid-operation clears all state immediately (async). A pending NMI is discarded and the next fetch is the RESET sequence.
- NMI latency: `nNMI` low before posedge k gives `nmiSync2` low after k+1, then `nmiEdge` high in the cycle after k+1, then `nmiPending`=1 after k+2. The earliest fetch that takes it closes at posedge k+3.
- IRQ latency: `nIRQ` low before posedge k gives `irqSync2` low after k+1. A fetch closing at k+2 or later takes it, provided `iFlag`=0 at that fetch.
- `iFlag` is used unsynchronised (internal signal), sampled in the fetch cycle itself.
- `opcodeNext` changes within the same cycle as `dataBus`, `getInstruction`-independent (decoder runs continuously).
- Back-to-back fetch cycles are legal; each posedge with `getInstruction`=1 is an independent fetch.

## Test plan
- Reset then first fetch with `dataBus`=0xA9 -> `opcodeNext`=0x00; after the edge `opcode`=0x00, `interruptSource`=1, `pcHold`=1. Second fetch with 0xA9 -> `opcode`=0xA9, `interruptSource`=0, `pcHold`=0.
- Plain fetch stream 0xA9, 0x8D, 0xEA with pins idle -> `opcode` follows each value one edge after its fetch; holds between fetches.
- `nNMI` pulsed low for 1 cycle at k, fetch at k+3 with `dataBus`=0x4C -> `opcode`=0x00, `interruptSource`=2. Next fetch -> 0x4C, source 0. A fetch at k+2 instead still returns 0x4C.
- `nIRQ` held low: fetch with `iFlag`=1 -> `dataBus` passes, source 0. Then `iFlag`=0 -> BRK, source 3. Then `nIRQ` released 3 cycles before the next fetch -> source 0.
- NMI and IRQ both active at a fetch -> source 2. The following fetch, with IRQ still low and `iFlag`=0 -> source 3.
- A second `nNMI` falling edge landing on the same posedge as the NMI-clearing fetch -> `nmiPending` stays 1; the next fetch is also NMI. Also: `nrst` asserted while `nmiPending`=1 -> after release, first fetch reports source 1 and the following fetch reports source 0.
